// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants, reader state type and the 6-bit bit-reverse helper
package fft_pkg;
    localparam int FFT_N     = 64;
    localparam int FFT_LOG2N = 6;

    typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev6(input logic [FFT_LOG2N-1:0] a);
        logic [FFT_LOG2N-1:0] r;
        for (int i = 0; i < FFT_LOG2N; i++) r[i] = a[FFT_LOG2N-1-i];
        return r;
    endfunction
endpackage

// File: rtl/fft_output_unit_if.sv
// fft_output_unit_if: sample bus of the FFT output stage
//   data_in_en/re/im         : bit-reversed samples from the last butterfly (master -> slave)
//   data_out_valid/re/im/index/last : natural-order stream (slave -> master)
interface fft_output_unit_if #(
    parameter int WIDTH = 10
);
    logic                               data_in_en;
    logic [WIDTH-1:0]                   data_in_re;
    logic [WIDTH-1:0]                   data_in_im;
    logic                               data_out_valid;
    logic [WIDTH-1:0]                   data_out_re;
    logic [WIDTH-1:0]                   data_out_im;
    logic [fft_pkg::FFT_LOG2N-1:0]      data_out_index;
    logic                               data_out_last;

    modport master (
        output data_in_en, data_in_re, data_in_im,
        input  data_out_valid, data_out_re, data_out_im, data_out_index, data_out_last
    );
    modport slave (
        input  data_in_en, data_in_re, data_in_im,
        output data_out_valid, data_out_re, data_out_im, data_out_index, data_out_last
    );
endinterface

// File: rtl/fft_reorder_ram.sv
// fft_reorder_ram: two-bank reorder memory, one write port, one synchronous read port
//   clk     : clock
//   i_we    : write enable
//   i_waddr : {bank, index} write address
//   i_wdata : {re, im} write data
//   i_raddr : {bank, index} read address
//   o_rdata : registered read data
module fft_reorder_ram
    import fft_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [FFT_LOG2N:0]     i_waddr,
    input  logic [2*WIDTH-1:0]     i_wdata,
    input  logic [FFT_LOG2N:0]     i_raddr,
    output logic [2*WIDTH-1:0]     o_rdata
);
    logic [2*WIDTH-1:0] r_mem [2*FFT_N];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/fft_output_unit.sv
// fft_output_unit: ping-pong reorder of bit-reversed FFT results into a natural-order stream
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fft_output_unit_if.slave (data_in_* in, data_out_* out)
//   FFT_OUT_BITREV_EN defined   : write address is bitrev6(wc), output in natural order
//   FFT_OUT_BITREV_EN undefined : write address is wc, output in arrival order
module fft_output_unit
    import fft_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    fft_output_unit_if.slave bus
);
    rd_state_t              r_state, w_state;
    logic [FFT_LOG2N-1:0]   r_wc, w_wc, r_rc, w_rc, r_idx1, w_wa, r_out_idx;
    logic                   r_wb, w_wb, r_rd_bank, w_rd_bank, r_pend, w_pend, r_pend_bank, w_pend_bank;
    logic                   r_v1, r_out_valid, r_out_last, w_launch;
    logic [WIDTH-1:0]       r_out_re, r_out_im;
    logic [2*WIDTH-1:0]     w_rdata;

    assign w_launch = bus.data_in_en && (&r_wc);

`ifdef FFT_OUT_BITREV_EN
    assign w_wa = bitrev6(r_wc);
`else
    assign w_wa = r_wc;
`endif

    fft_reorder_ram #(.WIDTH(WIDTH)) u_ram (
        .clk     (clk),
        .i_we    (bus.data_in_en),
        .i_waddr ({r_wb, w_wa}),
        .i_wdata ({bus.data_in_re, bus.data_in_im}),
        .i_raddr ({r_rd_bank, r_rc}),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_wc        = bus.data_in_en ? r_wc + 1'b1 : r_wc;
        w_wb        = r_wb ^ w_launch;
        w_state     = r_state;
        w_rc        = r_rc;
        w_rd_bank   = r_rd_bank;
        w_pend      = r_pend;
        w_pend_bank = r_pend_bank;
        // A frame boundary is either idle or the last read of a burst; a launch here starts with no gap.
        if (r_state == RD_IDLE || (&r_rc)) begin
            w_rc = '0;
            if (r_pend) begin
                w_state     = RD_READ;
                w_rd_bank   = r_pend_bank;
                w_pend      = w_launch;
                w_pend_bank = r_wb;
            end else if (w_launch) begin
                w_state   = RD_READ;
                w_rd_bank = r_wb;
            end else begin
                w_state = RD_IDLE;
            end
        end else begin
            w_rc = r_rc + 1'b1;
            if (w_launch) begin
                w_pend      = 1'b1;
                w_pend_bank = r_wb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RD_IDLE;
            r_wc        <= '0;
            r_wb        <= 1'b0;
            r_rc        <= '0;
            r_rd_bank   <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_bank <= 1'b0;
            r_v1        <= 1'b0;
            r_idx1      <= '0;
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_wc        <= w_wc;
            r_wb        <= w_wb;
            r_rc        <= w_rc;
            r_rd_bank   <= w_rd_bank;
            r_pend      <= w_pend;
            r_pend_bank <= w_pend_bank;
            r_v1        <= (r_state == RD_READ);
            r_idx1      <= r_rc;
            r_out_valid <= r_v1;
            if (r_v1) begin
                {r_out_re, r_out_im} <= w_rdata;
                r_out_idx            <= r_idx1;
                r_out_last           <= &r_idx1;
            end
        end
    end

    assign bus.data_out_valid = r_out_valid;
    assign bus.data_out_re    = r_out_re;
    assign bus.data_out_im    = r_out_im;
    assign bus.data_out_index = r_out_idx;
    assign bus.data_out_last  = r_out_last;
endmodule
